instr_encoder: RTL and testbench

Encoder side of the control decoder: converts instruction-class requests (R-type, lw, sw, beq) into 32-bit RV32I machine words and writes them sequentially into instruction memory through a single write port. Used by the test/boot path to load programs that the datapath fetches and the control decoder then decodes. Requests use a valid/ready handshake; each accepted request yields one registered memory write.

---
 rtl/instr_encoder.sv | 113 +++++++++++
 tb/tb_instr_encoder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Encodes R-type/lw/sw/beq requests into RV32I words and writes them one at a
// time into instruction memory through a single registered write port.
//
// state | meaning
// IDLE  | ready for a request; legal request latches word/address, illegal sets err
// WRITE | imem_we asserted with latched address/data; count advances at exit
module instr_encoder #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [2:0]        req_funct3,
  input  logic              req_f7b5,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;

  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (req_op)
      2'd0: begin
        enc_word    = {1'b0, req_f7b5, 5'b00000, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
        // funct7[5] is only meaningful for sub (000) and sra (101)
        enc_illegal = req_f7b5 && (req_funct3 != 3'b000) && (req_funct3 != 3'b101);
      end
      2'd1: enc_word = {req_imm[11:0], req_rs1, 3'b010, req_rd, OP_LOAD};
      2'd2: enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], OP_STORE};
      default: begin
        enc_word    = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                       req_imm[4:1], req_imm[11], OP_BRANCH};
        enc_illegal = req_imm[0];
      end
    endcase
  end

  // count never exceeds DEPTH, so its MSB alone marks the full condition
  assign full = count_q[ADDR_W];

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    imem_we   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !full && !clear && !reset;
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (!enc_illegal) state_nxt = WRITE;
        end
      end
      WRITE: begin
        imem_we   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state   <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept && enc_illegal) err_q <= 1'b1;
      if (accept && !enc_illegal) begin
        addr_q  <= BASE_ADDR + count_q[ADDR_W-1:0];
        wdata_q <= enc_word;
      end
      if (state == WRITE) count_q <= count_q + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (ADDR_W=2): expected writes are queued on
// acceptance and compared by a monitor whenever imem_we is seen.
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [2:0]    req_funct3 = '0;
  logic          req_f7b5 = 1'b0;
  logic [4:0]    req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [12:0]   req_imm = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR('0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_funct3(req_funct3), .req_f7b5(req_f7b5),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [AW+31:0] exp_q[$];
  int we_cyc[$];
  logic [AW-1:0] exp_addr = '0;
  logic [AW:0]   exp_count = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%h", imem_addr, imem_wdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          failures++;
          $display("FAIL write_data got addr=%0h data=%h exp addr=%0h data=%h",
                   imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
        end
      end
      checks++;
      if (req_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_in_write got=%b exp=0", req_ready);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [12:0] imm, input logic legal, input logic [31:0] word);
    int n;
    @(negedge clk);
    req_op = op; req_funct3 = f3; req_f7b5 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    #1;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout got=%b exp=1", req_ready);
      req_valid = 1'b0;
    end else begin
      if (legal) begin
        exp_q.push_back({exp_addr, word});
        exp_addr++;
        exp_count++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_req();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL clear_ready got=%b exp=0", req_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    exp_addr = '0;
    exp_count = '0;
    #1;
    checks++;
    if ({count, full, err} !== {3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clear_state got count=%0d full=%b err=%b exp 0/0/0", count, full, err);
    end
  endtask

  task automatic check_count(input string name);
    checks++;
    if (count !== exp_count) begin
      failures++;
      $display("FAIL %s count got=%0d exp=%0d", name, count, exp_count);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, imem_we, imem_addr, imem_wdata, count, full, err} !==
        {1'b0, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got rdy=%b we=%b addr=%0h data=%h cnt=%0d full=%b err=%b exp 0/0/0/0/0/0/0",
               req_ready, imem_we, imem_addr, imem_wdata, count, full, err);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_after got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_add();
    send(2'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3);
    release_req();
    drain();
    check_count("add");
    checks++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b0, 2'd0, 32'h002081B3}) begin
      failures++;
      $display("FAIL add_hold got we=%b addr=%0h data=%h exp we=0 addr=0 data=002081b3",
               imem_we, imem_addr, imem_wdata);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    we_cyc.delete();
    send(2'd0, 3'b000, 1'b1, 5'd5, 5'd6, 5'd7, 13'd0, 1'b1, 32'h407302B3);
    send(2'd1, 3'b000, 1'b0, 5'd4, 5'd2, 5'd0, 13'd8, 1'b1, 32'h00812203);
    release_req();
    drain();
    check_count("b2b");
    checks++;
    if (we_cyc.size() != 2) begin
      failures++; $display("FAIL b2b_strobes got=%0d exp=2", we_cyc.size());
    end else if (we_cyc[1] - we_cyc[0] != 2) begin
      failures++; $display("FAIL b2b_spacing got=%0d exp=2", we_cyc[1] - we_cyc[0]);
    end
  endtask

  task automatic test_store_branch();
    pulse_clear();
    // unused funct3/f7b5 on sw must neither change the word nor flag an error
    send(2'd2, 3'b001, 1'b1, 5'd9, 5'd2, 5'd4, 13'd12, 1'b1, 32'h00412623);
    send(2'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1, 32'hFE208CE3);
    send(2'd1, 3'b000, 1'b0, 5'd31, 5'd0, 5'd17, 13'h1FFF, 1'b1, 32'hFFF02F83);
    release_req();
    drain();
    check_count("store_branch");
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL store_branch_err got=%b exp=0", err);
    end
  endtask

  task automatic test_errors();
    pulse_clear();
    send(2'd0, 3'b001, 1'b1, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'h0);
    release_req();
    repeat (3) @(negedge clk);
    checks++;
    if ({err, count} !== {1'b1, 3'd0}) begin
      failures++; $display("FAIL err_rtype got err=%b count=%0d exp err=1 count=0", err, count);
    end
    pulse_clear();
    send(2'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h0005, 1'b0, 32'h0);
    release_req();
    repeat (3) @(negedge clk);
    checks++;
    if ({err, count} !== {1'b1, 3'd0}) begin
      failures++; $display("FAIL err_beq got err=%b count=%0d exp err=1 count=0", err, count);
    end
    send(2'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3);
    release_req();
    drain();
    check_count("err_then_add");
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%b exp=1", err);
    end
  endtask

  task automatic test_reset_during_write();
    send(2'd0, 3'b111, 1'b0, 5'd10, 5'd11, 5'd12, 13'd0, 1'b1, 32'h00C5F533);
    release_req();
    reset = 1'b1;
    exp_addr = '0;
    exp_count = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({imem_we, count, err, req_ready} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_in_write got we=%b count=%0d err=%b rdy=%b exp 0/0/0/0",
               imem_we, count, err, req_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_we, req_ready} !== {1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_in_write_after got we=%b rdy=%b exp we=0 rdy=1", imem_we, req_ready);
    end
    check_count("reset_in_write");
  endtask

  task automatic test_full();
    pulse_clear();
    send(2'd0, 3'b111, 1'b0, 5'd10, 5'd11, 5'd12, 13'd0, 1'b1, 32'h00C5F533);
    send(2'd0, 3'b101, 1'b1, 5'd1, 5'd2, 5'd3, 13'd0, 1'b1, 32'h403150B3);
    send(2'd2, 3'b000, 1'b0, 5'd0, 5'd2, 5'd4, 13'd12, 1'b1, 32'h00412623);
    send(2'd1, 3'b000, 1'b0, 5'd4, 5'd2, 5'd0, 13'd8, 1'b1, 32'h00812203);
    release_req();
    drain();
    checks++;
    if ({count, full, req_ready} !== {3'd4, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL full_state got count=%0d full=%b rdy=%b exp 4/1/0", count, full, req_ready);
    end
    req_op = 2'd0; req_funct3 = 3'b000; req_f7b5 = 1'b0;
    req_rd = 5'd3; req_rs1 = 5'd1; req_rs2 = 5'd2; req_imm = '0;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || count !== 3'd4) begin
        failures++;
        $display("FAIL full_hold got rdy=%b count=%0d exp rdy=0 count=4", req_ready, count);
      end
    end
    clear = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL clear_vs_valid got rdy=%b exp=0", req_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if ({count, full, req_ready} !== {3'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL full_cleared got count=%0d full=%b rdy=%b exp 0/0/1", count, full, req_ready);
    end
    exp_q.push_back({2'd0, 32'h002081B3});
    exp_addr = 2'd1;
    exp_count = 3'd1;
    @(posedge clk);
    #1;
    release_req();
    drain();
    check_count("after_full_clear");
    checks++;
    if (full !== 1'b0) begin
      failures++; $display("FAIL after_full_clear_full got=%b exp=0", full);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_store_branch();
    test_errors();
    test_reset_during_write();
    test_full();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL final_queue got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
